// File: rtl/seq_det_pkg.sv
// Shared constants and the masked pattern compare used by the sequence detector.
package seq_det_pkg;

  localparam int SEQ_MAX_LEN = 8;
  localparam int SEQ_LEN_W = $clog2(SEQ_MAX_LEN + 1);

  localparam int         SEQ_DEF_LEN     = 4;
  localparam logic [7:0] SEQ_DEF_PATTERN = 8'b0000_1011;
  localparam bit         SEQ_DEF_OVERLAP = 1'b1;

  // Working width of the compare helper; callers zero-extend into it.
  localparam int SEQ_CMP_W = 32;

  // True when the low 'len' bits of pattern and history agree; upper bits ignored.
  function automatic logic masked_match(input logic [SEQ_CMP_W-1:0] pat,
                                        input logic [SEQ_CMP_W-1:0] hist,
                                        input logic [SEQ_CMP_W-1:0] len);
    logic [SEQ_CMP_W-1:0] mask;
    if (len >= SEQ_CMP_W) mask = '1;
    else                  mask = (SEQ_CMP_W'(1) << len) - SEQ_CMP_W'(1);
    return ((pat ^ hist) & mask) == '0;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module seq_det_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   count <= '0;
    else if (clr)                count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial sequence detector with overlap control and match count.
module seq_det_param #(
  parameter int                 MAX_LEN     = seq_det_pkg::SEQ_MAX_LEN,
  parameter int                 DEF_LEN     = seq_det_pkg::SEQ_DEF_LEN,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_det_pkg::SEQ_DEF_PATTERN),
  parameter bit                 DEF_OVERLAP = seq_det_pkg::SEQ_DEF_OVERLAP,
  parameter int                 CNT_W       = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           sequence_in,
  input  logic                           in_valid,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  output logic                           detector_out,
  output logic [CNT_W-1:0]               match_count,
  output logic                           cfg_error
);

  import seq_det_pkg::*;

  localparam int               LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0]   pat_q;
  logic [LEN_W-1:0]     len_q;
  logic                 ovl_q;
  logic [MAX_LEN-1:0]   hist_q;
  logic [LEN_W-1:0]     fill_q;

  logic                 load_ok;
  logic                 sample;
  logic [MAX_LEN-1:0]   hist_next;
  logic [LEN_W-1:0]     fill_next;
  logic                 hit;

  // Qualify the load, form the post-shift history and decide whether this sample matches.
  always_comb begin
    load_ok   = cfg_load && (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    // A valid load drops the bit presented in the same cycle.
    sample    = in_valid && !load_ok;
    hist_next = {hist_q[MAX_LEN-2:0], sequence_in};
    fill_next = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
    hit       = sample && (fill_next >= len_q) &&
                masked_match(SEQ_CMP_W'(pat_q), SEQ_CMP_W'(hist_next), SEQ_CMP_W'(len_q));
  end

  // Configuration, history, fill level and the registered match/error pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat_q        <= DEF_PATTERN;
      len_q        <= LEN_W'(DEF_LEN);
      ovl_q        <= DEF_OVERLAP;
      hist_q       <= '0;
      fill_q       <= '0;
      detector_out <= 1'b0;
      cfg_error    <= 1'b0;
    end else if (load_ok) begin
      pat_q        <= cfg_pattern;
      len_q        <= cfg_len;
      ovl_q        <= cfg_overlap;
      hist_q       <= '0;
      fill_q       <= '0;
      detector_out <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      // Any load reaching here had an out-of-range length.
      cfg_error    <= cfg_load;
      detector_out <= hit;
      if (sample) begin
        hist_q <= hist_next;
        // Non-overlapping mode needs a full fresh pattern after every match.
        fill_q <= (hit && !ovl_q) ? '0 : fill_next;
      end
    end
  end

  seq_det_sat_counter #(
    .CNT_W (CNT_W)
  ) u_count (
    .clock (clock),
    .reset (reset),
    .inc   (hit),
    .clr   (load_ok),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param; a second instance with a 2-bit counter covers saturation.
module tb_seq_det_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sequence_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [3:0] cfg_len = 4'd0;
  logic       cfg_overlap = 1'b0;

  logic        detector_out;
  logic [15:0] match_count;
  logic        cfg_error;
  logic        det_s;
  logic [1:0]  cnt_s;
  logic        err_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  seq_det_param dut (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .in_valid     (in_valid),
    .cfg_load     (cfg_load),
    .cfg_pattern  (cfg_pattern),
    .cfg_len      (cfg_len),
    .cfg_overlap  (cfg_overlap),
    .detector_out (detector_out),
    .match_count  (match_count),
    .cfg_error    (cfg_error)
  );

  seq_det_param #(.CNT_W(2)) dut_sat (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .in_valid     (in_valid),
    .cfg_load     (cfg_load),
    .cfg_pattern  (cfg_pattern),
    .cfg_len      (cfg_len),
    .cfg_overlap  (cfg_overlap),
    .detector_out (det_s),
    .match_count  (cnt_s),
    .cfg_error    (err_s)
  );

  task automatic step(input logic b, input logic v);
    sequence_in = b;
    in_valid    = v;
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o,
                         input logic b, input logic v);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_load    = 1'b1;
    step(b, v);
    cfg_load    = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_cmp++;
    if (detector_out !== 1'b0) begin n_bad++; $display("FAIL reset_det got %0b want 0", detector_out); end
    n_cmp++;
    if (match_count !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", match_count); end
    n_cmp++;
    if (cfg_error !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", cfg_error); end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      step(bits[6-i], 1'b1);
      n_cmp++;
      if (detector_out !== exp[6-i]) begin
        n_bad++; $display("FAIL ovl_det bit%0d got %0b want %0b", i, detector_out, exp[6-i]);
      end
    end
    n_cmp++;
    if (match_count !== 16'd2) begin n_bad++; $display("FAIL ovl_cnt got %0d want 2", match_count); end
  endtask

  task automatic test_no_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001000;
    do_load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (match_count !== 16'd0) begin n_bad++; $display("FAIL novl_clr got %0d want 0", match_count); end
    for (int i = 0; i < 7; i++) begin
      step(bits[6-i], 1'b1);
      n_cmp++;
      if (detector_out !== exp[6-i]) begin
        n_bad++; $display("FAIL novl_det bit%0d got %0b want %0b", i, detector_out, exp[6-i]);
      end
    end
    n_cmp++;
    if (match_count !== 16'd1) begin n_bad++; $display("FAIL novl_cnt got %0d want 1", match_count); end
  endtask

  task automatic test_back_to_back();
    do_load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if (detector_out !== 1'b1) begin n_bad++; $display("FAIL b2b_det bit%0d got %0b want 1", i, detector_out); end
    end
    n_cmp++;
    if (match_count !== 16'd3) begin n_bad++; $display("FAIL b2b_cnt got %0d want 3", match_count); end
    step(1'b1, 1'b0);
    n_cmp++;
    if (detector_out !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %0b want 0", detector_out); end
  endtask

  task automatic test_idle_gaps();
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    n_cmp++;
    if (detector_out !== 1'b0) begin n_bad++; $display("FAIL gap_pre got %0b want 0", detector_out); end
    for (int i = 0; i < 5; i++) begin
      step(i[0], 1'b0);
      n_cmp++;
      if (detector_out !== 1'b0) begin n_bad++; $display("FAIL gap_idle%0d got %0b want 0", i, detector_out); end
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if (detector_out !== 1'b1) begin n_bad++; $display("FAIL gap_hit got %0b want 1", detector_out); end
    n_cmp++;
    if (match_count !== 16'd1) begin n_bad++; $display("FAIL gap_cnt got %0d want 1", match_count); end
  endtask

  task automatic test_reject();
    logic [7:0] a5 = 8'hA5;
    // History ends ...1011 here; the bit sampled during each rejected load must be kept.
    do_load(8'hFF, 4'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (cfg_error !== 1'b1) begin n_bad++; $display("FAIL rej0_err got %0b want 1", cfg_error); end
    do_load(8'hFF, 4'd9, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (cfg_error !== 1'b1) begin n_bad++; $display("FAIL rej9_err got %0b want 1", cfg_error); end
    n_cmp++;
    if (detector_out !== 1'b0) begin n_bad++; $display("FAIL rej9_det got %0b want 0", detector_out); end
    step(1'b1, 1'b1);
    n_cmp++;
    if (cfg_error !== 1'b0) begin n_bad++; $display("FAIL rej_errclr got %0b want 0", cfg_error); end
    n_cmp++;
    if (detector_out !== 1'b1) begin n_bad++; $display("FAIL rej_cfgkept got %0b want 1", detector_out); end
    n_cmp++;
    if (match_count !== 16'd2) begin n_bad++; $display("FAIL rej_cnt got %0d want 2", match_count); end
    do_load(8'hA5, 4'd8, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (cfg_error !== 1'b0 || match_count !== 16'd0) begin
      n_bad++; $display("FAIL len8_load got err=%0b cnt=%0d want err=0 cnt=0", cfg_error, match_count);
    end
    for (int i = 0; i < 8; i++) begin
      step(a5[7-i], 1'b1);
      n_cmp++;
      if (detector_out !== (i == 7)) begin
        n_bad++; $display("FAIL len8_det bit%0d got %0b want %0b", i, detector_out, (i == 7));
      end
    end
    n_cmp++;
    if (match_count !== 16'd1) begin n_bad++; $display("FAIL len8_cnt got %0d want 1", match_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    n_cmp++;
    if (detector_out !== 1'b1) begin n_bad++; $display("FAIL ar_pre got %0b want 1", detector_out); end
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    // Without the reset, one more 1 would complete 1011 from this history.
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (match_count !== 16'd0 || detector_out !== 1'b0) begin
      n_bad++; $display("FAIL ar_immediate got det=%0b cnt=%0d want 0/0", detector_out, match_count);
    end
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    step(1'b1, 1'b1);
    n_cmp++;
    if (detector_out !== 1'b0) begin n_bad++; $display("FAIL ar_nopulse got %0b want 0", detector_out); end
    n_cmp++;
    if (match_count !== 16'd0) begin n_bad++; $display("FAIL ar_cnt got %0d want 0", match_count); end
  endtask

  task automatic test_saturation();
    do_load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    n_cmp++;
    if (cnt_s !== 2'd3) begin n_bad++; $display("FAIL sat_cnt2 got %0d want 3", cnt_s); end
    n_cmp++;
    if (det_s !== 1'b1) begin n_bad++; $display("FAIL sat_det got %0b want 1", det_s); end
    n_cmp++;
    if (match_count !== 16'd5) begin n_bad++; $display("FAIL sat_cnt16 got %0d want 5", match_count); end
    step(1'b1, 1'b1);
    n_cmp++;
    if (cnt_s !== 2'd3) begin n_bad++; $display("FAIL sat_hold got %0d want 3", cnt_s); end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_back_to_back();
    test_idle_gaps();
    test_reject();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised, runtime-programmable serial sequence detector. Successor to the fixed-pattern Moore detector.
- Samples one bit per qualified clock and compares the most recent N bits against a loadable pattern of length 1..MAX_LEN.
- Overlapping or non-overlapping detection is selectable.
- Emits a registered one-cycle match pulse and keeps a saturating match count. Sits on a serial input stream feeding control/status logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- DEF_LEN, 4, pattern length after reset (1..MAX_LEN).
- DEF_PATTERN, 8'b0000_1011, pattern after reset; only the low DEF_LEN bits are used.
- DEF_OVERLAP, 1, overlap mode after reset (1 = overlapping).
- CNT_W, 16, match counter width.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- sequence_in  in  1  serial data bit.
- in_valid  in  1  sequence_in is sampled only when high.
- cfg_load  in  1  one-cycle strobe that loads the configuration below.
- cfg_pattern  in  MAX_LEN  new pattern; bit [cfg_len-1] is the first bit expected.
- cfg_len  in  clog2(MAX_LEN+1)  new pattern length.
- cfg_overlap  in  1  new overlap mode.
- detector_out  out  1  registered match pulse.
- match_count  out  CNT_W  number of matches since the last reset or valid load; saturating.
- cfg_error  out  1  one-cycle pulse flagging a rejected load.

Behaviour:
- Reset (async, active-high) applies immediately:
  - hist = 0, fill = 0.
  - Active config = DEF_PATTERN / DEF_LEN / DEF_OVERLAP.
  - detector_out = 0, match_count = 0, cfg_error = 0.
  - Mid-stream reset discards any partial match.
- State:
  - hist: MAX_LEN-bit shift register. On each valid sample, shift left and put sequence_in in the LSB.
  - fill: count of valid bits held, saturating at MAX_LEN.
- Match condition, evaluated on a valid sample using the post-shift values: (fill_next >= len) and (hist_next[len-1:0] == pat[len-1:0]).
- Latency: detector_out goes high on the clock edge that samples the final pattern bit, for exactly one cycle.
  - Back-to-back matches, possible only in overlap mode (for example len=1, or pattern 11 on 111), keep detector_out high on consecutive cycles.
- in_valid low: hist and fill hold; detector_out goes to 0 at the next edge.
- Overlap mode 1: after a match, fill and hist continue, so a suffix of the match can start the next match.
- Overlap mode 0: on a match, fill is set to 0, so the next match needs len fresh bits.
- match_count increments by 1 per match and saturates at 2^CNT_W-1 with no wrap.
- cfg_load with 1 <= cfg_len <= MAX_LEN (valid load):
  - New config is active from the next edge.
  - hist, fill, match_count and detector_out are cleared at that edge.
  - in_valid in the same cycle is ignored, and that bit is dropped.
- cfg_load with cfg_len = 0 or cfg_len > MAX_LEN (rejected load):
  - Config is unchanged and no state is cleared.
  - Sampling proceeds normally that cycle.
  - cfg_error pulses high for 1 cycle.
- Pattern bits above len are don't-care and excluded from the compare.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package seq_det_pkg holds:
  - default constants (DEF_LEN, DEF_PATTERN, DEF_OVERLAP);
  - the length-width localparam derived from MAX_LEN;
  - a masked-compare helper function (pattern, history, len) -> match.
- One sub-module, seq_det_sat_counter: CNT_W saturating counter with inc and clr inputs and async reset.
- The shift/compare/config logic stays in the top level.

Test Plan:
- Reset defaults, overlap on, stream 1,0,1,1,0,1,1 with in_valid=1 every cycle:
  - detector_out pulses after the 4th and 7th bits;
  - match_count = 2.
- Same stream after loading cfg_overlap=0, cfg_len=4, cfg_pattern=1011:
  - a single pulse after the 4th bit;
  - match_count = 1.
- Load len=1, pattern=1, overlap=1, then stream 1,1,1:
  - detector_out stays high for 3 consecutive cycles;
  - match_count = 3.
- Default pattern, bits 1,0,1 valid, then in_valid low for 5 cycles, then bit 1 valid:
  - pulse only after the final valid bit;
  - hist and fill hold while in_valid is low;
  - detector_out is 0 while idle.
- Rejected loads:
  - cfg_load with cfg_len=0, then cfg_len=MAX_LEN+1: cfg_error pulses once for each; config and match_count are unchanged.
  - A subsequent valid load of len=8, pattern 8'hA5, followed by stream A5 MSB-first: one pulse.
- Async reset and saturation:
  - Assert reset mid-way through 1,0,1 (between clock edges), release, then send 1: no pulse; outputs go to 0 immediately on assertion.
  - With CNT_W=2, 5 matches: match_count stays at 3.
